safe_lock_fsm: RTL and testbench
================================

Name: safe_lock_fsm

Overview:
- Master control FSM of the digital safe; sits directly upstream of the servo PWM stage.
- Consumes debounced keypad events, verifies a PIN_LEN-digit PIN and tracks failed attempts with a timed lockout.
- Publishes a 4-bit `state` bus. The servo stage drives the bolt open only while `state == 4'b0111` (UNLOCK).
- All timing assumes a 50 MHz clk (20 ms = 1,000,000 cycles).

Parameters:
- PIN_LEN, 4, number of digits in a PIN (1..4).
- DEFAULT_PIN, 16'h1234, reset PIN as BCD digits, first-entered digit in the MS nibble used.
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..3).
- LOCKOUT_CYCLES, 500_000_000, lockout duration in clk cycles (10 s).
- UNLOCK_CYCLES, 250_000_000, auto-relock timeout in clk cycles (5 s).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key_code is valid
- key_code  in  4  key code: 0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC LOCK, 4'hD SETPIN; all others ignored
- state  out  4  FSM state encoding (see Behaviour)
- digit_cnt  out  3  digits entered so far
- fail_cnt  out  2  consecutive failed attempts
- beep  out  1  one-cycle pulse on every accepted key

Behaviour:
- Encodings:
  - IDLE 4'b0000
  - ENTRY 4'b0001
  - CHECK 4'b0010
  - FAIL 4'b0011
  - LOCKOUT 4'b0100
  - SETPIN 4'b0101
  - UNLOCK 4'b0111
  - 4'b0110 and 4'b1xxx are unused; if ever reached, go to IDLE next cycle.
- Reset (rst low, asynchronous): state=IDLE, digit_cnt=0, fail_cnt=0, beep=0, entry buffer=0, timer=0, stored PIN=DEFAULT_PIN.
- All outputs are registered; state changes one cycle after the triggering key_valid.
- Digit handling (IDLE, ENTRY, SETPIN):
  - Buffer <= {buf[11:0], digit}; digit_cnt increments, saturating at PIN_LEN.
  - Digits beyond PIN_LEN are ignored (no beep).
- IDLE: a digit → ENTRY. ENTER, CLEAR and LOCK beep but stay in IDLE.
- ENTRY:
  - CLEAR → IDLE, buffer and digit_cnt cleared.
  - ENTER → CHECK.
  - LOCK and SETPIN are ignored.
- CHECK lasts exactly 1 cycle:
  - Match only if digit_cnt==PIN_LEN and buf[4*PIN_LEN-1:0]==stored PIN low 4*PIN_LEN bits.
  - Match → UNLOCK with fail_cnt=0.
  - Otherwise → FAIL.
  - Buffer and digit_cnt are cleared on leaving CHECK.
- FAIL lasts exactly 1 cycle; fail_cnt+1.
  - New count == MAX_FAIL → LOCKOUT with timer=0.
  - Otherwise → IDLE.
- LOCKOUT:
  - All keys ignored (no beep).
  - Timer counts up; when it reaches LOCKOUT_CYCLES-1 → IDLE, fail_cnt=0.
- UNLOCK:
  - Timer starts at 0 on entry.
  - LOCK key, or timer reaching UNLOCK_CYCLES-1 → IDLE.
  - Digits, ENTER and CLEAR are ignored.
- Simultaneous events: a timer expiry and a key in the same cycle → the timer wins and the key is dropped.
- key_valid held high for N cycles counts as N keys (the upstream debouncer guarantees pulses).
- Timer width is $clog2 of the larger cycle parameter; the timer must not wrap before expiry.

Optional Feature:
- Macro: SAFE_PIN_CHANGE_EN.
- When defined:
  - SETPIN in UNLOCK → SETPIN state, buffer cleared, unlock timer frozen.
  - In SETPIN, ENTER with digit_cnt==PIN_LEN stores the buffer as the new PIN → IDLE.
  - ENTER with fewer digits, or CLEAR → IDLE with PIN unchanged.
  - SETPIN has no timeout.
- When undefined: SETPIN is never entered, key 4'hD is ignored everywhere, and the PIN is constant DEFAULT_PIN.

Test Plan:
- Sim parameters: UNLOCK_CYCLES=10, LOCKOUT_CYCLES=20.
- Reset, keys 1,2,3,4,ENTER → CHECK for 1 cycle, then state=4'b0111, fail_cnt=0. After 10 cycles with no key → 4'b0000.
- Keys 1,2,3,5,ENTER three times → fail_cnt 1,2, then LOCKOUT (4'b0100). Key 1 during lockout gives no beep and no change. After 20 cycles → IDLE, fail_cnt=0.
- Keys 1,2,ENTER → FAIL (short PIN), fail_cnt=1. Keys 1,2,CLEAR → IDLE, digit_cnt=0, fail_cnt unchanged.
- Keys 1,2,3,4,9,ENTER → 5th digit ignored with no beep, then UNLOCK. Send LOCK on cycle 3 → IDLE next cycle.
- Assert rst low while in UNLOCK and mid-lockout → immediate IDLE, all counters 0.
- With SAFE_PIN_CHANGE_EN: unlock, SETPIN, 9,8,7,6,ENTER → IDLE. Then 1,2,3,4 fails and 9,8,7,6 unlocks.

Source files
------------

// File: rtl/safe_lock_fsm_if.sv
// Keypad-event and status bundle between the keypad front end and the safe lock FSM.
// key_valid is a one-cycle strobe that qualifies key_code; there is no ready, the FSM
// either acts on or silently drops every strobe, and each high cycle counts as one key.
interface safe_lock_fsm_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] state;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic       beep;

  modport master (
    output key_valid, key_code,
    input  state, digit_cnt, fail_cnt, beep
  );

  modport slave (
    input  key_valid, key_code,
    output state, digit_cnt, fail_cnt, beep
  );
endinterface

// File: rtl/safe_lock_fsm.sv
// Safe lock controller: PIN entry, verification, failed-attempt lockout and auto-relock.
// Define SAFE_PIN_CHANGE_EN to allow changing the PIN while unlocked (SETPIN state).
module safe_lock_fsm #(
  parameter int          PIN_LEN        = 4,
  parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 500_000_000,
  parameter int          UNLOCK_CYCLES  = 250_000_000
) (
  input logic            clk,
  input logic            rst,
  safe_lock_fsm_if.slave kp
);
  localparam int MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    PIN_LEN_C    = 3'(PIN_LEN);
  localparam logic [1:0]    MAX_FAIL_C   = 2'(MAX_FAIL);
  localparam logic [15:0]   PIN_MASK     = 16'((32'd1 << (4 * PIN_LEN)) - 32'd1);

  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_ENTER = 4'hB;
  localparam logic [3:0] K_LOCK  = 4'hC;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_ENTRY   = 4'b0001,
    S_CHECK   = 4'b0010,
    S_FAIL    = 4'b0011,
    S_LOCKOUT = 4'b0100,
    S_SETPIN  = 4'b0101,
    S_UNLOCK  = 4'b0111
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          beep_q, beep_d;
  logic [15:0]   pin_cur;

`ifdef SAFE_PIN_CHANGE_EN
  localparam logic [3:0] K_SETPIN = 4'hD;
  logic [15:0] pin_q, pin_d;
  logic        key_setpin;
  assign pin_cur    = pin_q;
  assign key_setpin = kp.key_valid && (kp.key_code == K_SETPIN);
`else
  assign pin_cur = DEFAULT_PIN;
`endif

  logic        digit_ok, key_clear, key_enter, key_lock, pin_match;
  logic [15:0] buf_shift;

  // A digit is only accepted while the buffer still has room for it.
  assign digit_ok  = kp.key_valid && (kp.key_code <= 4'd9) && (cnt_q < PIN_LEN_C);
  assign key_clear = kp.key_valid && (kp.key_code == K_CLEAR);
  assign key_enter = kp.key_valid && (kp.key_code == K_ENTER);
  assign key_lock  = kp.key_valid && (kp.key_code == K_LOCK);
  assign buf_shift = {buf_q[11:0], kp.key_code};
  assign pin_match = (cnt_q == PIN_LEN_C) && ((buf_q & PIN_MASK) == (pin_cur & PIN_MASK));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    beep_d  = 1'b0;
`ifdef SAFE_PIN_CHANGE_EN
    pin_d   = pin_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (digit_ok) begin
          buf_d   = buf_shift;
          cnt_d   = cnt_q + 3'd1;
          beep_d  = 1'b1;
          state_d = S_ENTRY;
        end else if (key_enter || key_clear || key_lock) begin
          beep_d = 1'b1;
        end
      end
      S_ENTRY: begin
        if (digit_ok) begin
          buf_d  = buf_shift;
          cnt_d  = cnt_q + 3'd1;
          beep_d = 1'b1;
        end else if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          beep_d  = 1'b1;
          state_d = S_IDLE;
        end else if (key_enter) begin
          beep_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (pin_match) begin
          fail_d  = '0;
          timer_d = '0;
          state_d = S_UNLOCK;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
        fail_d = fail_q + 2'd1;
        if ((fail_q + 2'd1) == MAX_FAIL_C) begin
          timer_d = '0;
          state_d = S_LOCKOUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCKOUT_LAST) begin
          fail_d  = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_UNLOCK: begin
        // Expiry is tested first so a key arriving on the same cycle is dropped.
        if (timer_q == UNLOCK_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else if (key_lock) begin
          timer_d = '0;
          beep_d  = 1'b1;
          state_d = S_IDLE;
`ifdef SAFE_PIN_CHANGE_EN
        end else if (key_setpin) begin
          buf_d   = '0;
          cnt_d   = '0;
          beep_d  = 1'b1;
          state_d = S_SETPIN;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef SAFE_PIN_CHANGE_EN
      S_SETPIN: begin
        if (digit_ok) begin
          buf_d  = buf_shift;
          cnt_d  = cnt_q + 3'd1;
          beep_d = 1'b1;
        end else if (key_enter || key_clear) begin
          if (key_enter && (cnt_q == PIN_LEN_C)) begin
            pin_d = buf_q;
          end
          buf_d   = '0;
          cnt_d   = '0;
          beep_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      beep_q  <= 1'b0;
`ifdef SAFE_PIN_CHANGE_EN
      pin_q   <= DEFAULT_PIN;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      beep_q  <= beep_d;
`ifdef SAFE_PIN_CHANGE_EN
      pin_q   <= pin_d;
`endif
    end
  end

  assign kp.state     = state_q;
  assign kp.digit_cnt = cnt_q;
  assign kp.fail_cnt  = fail_q;
  assign kp.beep      = beep_q;
endmodule

// File: tb/tb_safe_lock_fsm.sv
// Self-checking bench for safe_lock_fsm: vector table, hand-written timing/reset sequences
// and randomized key streams checked against a queue-based reference model.
module tb_safe_lock_fsm;
  localparam int          PIN_LEN        = 4;
  localparam logic [15:0] DEFAULT_PIN    = 16'h1234;
  localparam int          MAX_FAIL       = 3;
  localparam int          UNLOCK_CYCLES  = 10;
  localparam int          LOCKOUT_CYCLES = 20;

  localparam int ST_IDLE = 0, ST_ENTRY = 1, ST_CHECK = 2, ST_FAIL = 3;
  localparam int ST_LOCKOUT = 4, ST_SETPIN = 5, ST_UNLOCK = 7;

  localparam logic [3:0] K_CLEAR = 4'hA, K_ENTER = 4'hB, K_LOCK = 4'hC, K_SETPIN = 4'hD;

`ifdef SAFE_PIN_CHANGE_EN
  localparam bit PIN_CHANGE = 1'b1;
`else
  localparam bit PIN_CHANGE = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  safe_lock_fsm_if kp ();

  safe_lock_fsm #(
    .PIN_LEN(PIN_LEN), .DEFAULT_PIN(DEFAULT_PIN), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int cnt, input int fl, input int bp);
    check({tag, "_state"}, int'(kp.state), st);
    check({tag, "_digit_cnt"}, int'(kp.digit_cnt), cnt);
    check({tag, "_fail_cnt"}, int'(kp.fail_cnt), fl);
    check({tag, "_beep"}, int'(kp.beep), bp);
  endtask

  // reference model: entered digits and PIN as digit queues, timed states as a countdown
  int m_state;
  int m_digits[$];
  int m_pin[$];
  int m_fails;
  int m_left;
  int m_beep;

  task automatic model_reset();
    m_state = ST_IDLE;
    m_digits.delete();
    m_pin.delete();
    for (int i = PIN_LEN - 1; i >= 0; i--) m_pin.push_back(int'((DEFAULT_PIN >> (4 * i)) & 16'hF));
    m_fails = 0;
    m_left  = 0;
    m_beep  = 0;
  endtask

  function automatic bit model_pin_ok();
    if (m_digits.size() != PIN_LEN) return 1'b0;
    for (int i = 0; i < PIN_LEN; i++) if (m_digits[i] != m_pin[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic v, input logic [3:0] c);
    bit room, dig, clr, ent, lck, spn;
    room = m_digits.size() < PIN_LEN;
    dig  = v && (c <= 4'd9);
    clr  = v && (c == K_CLEAR);
    ent  = v && (c == K_ENTER);
    lck  = v && (c == K_LOCK);
    spn  = v && (c == K_SETPIN) && PIN_CHANGE;
    m_beep = 0;
    case (m_state)
      ST_IDLE: begin
        if (dig && room) begin
          m_digits.push_back(int'(c)); m_beep = 1; m_state = ST_ENTRY;
        end else if (ent || clr || lck) m_beep = 1;
      end
      ST_ENTRY, ST_SETPIN: begin
        if (dig && room) begin
          m_digits.push_back(int'(c)); m_beep = 1;
        end else if (clr) begin
          m_digits.delete(); m_beep = 1; m_state = ST_IDLE;
        end else if (ent && m_state == ST_ENTRY) begin
          m_beep = 1; m_state = ST_CHECK;
        end else if (ent) begin
          if (m_digits.size() == PIN_LEN) m_pin = m_digits;
          m_digits.delete(); m_beep = 1; m_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (model_pin_ok()) begin
          m_state = ST_UNLOCK; m_fails = 0; m_left = UNLOCK_CYCLES;
        end else m_state = ST_FAIL;
        m_digits.delete();
      end
      ST_FAIL: begin
        m_fails++;
        if (m_fails == MAX_FAIL) begin
          m_state = ST_LOCKOUT; m_left = LOCKOUT_CYCLES;
        end else m_state = ST_IDLE;
      end
      ST_LOCKOUT: begin
        m_left--;
        if (m_left == 0) begin
          m_state = ST_IDLE; m_fails = 0;
        end
      end
      ST_UNLOCK: begin
        m_left--;
        if (m_left == 0) m_state = ST_IDLE;
        else if (lck) begin
          m_beep = 1; m_state = ST_IDLE;
        end else if (spn) begin
          m_beep = 1; m_digits.delete(); m_state = ST_SETPIN;
        end
      end
      default: m_state = ST_IDLE;
    endcase
  endtask

  // driver: one key slot per clock, checked against the model after the edge
  task automatic step(input logic v, input logic [3:0] c);
    @(negedge clk);
    kp.key_valid = v;
    kp.key_code  = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    kp.key_valid = 1'b0;
    check_outs("model", m_state, m_digits.size(), m_fails, m_beep);
  endtask

  task automatic enter_code(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) step(1'b1, code[15 - 4 * i -: 4]);
    step(1'b1, K_ENTER);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outs(tag, ST_IDLE, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fail_to_lockout();
    for (int r = 0; r < MAX_FAIL; r++) begin
      enter_code(16'h1235, 4);
      check_outs("bad_enter", ST_CHECK, 4, r, 1);
      step(1'b0, 4'h0);
      check_outs("bad_fail", ST_FAIL, 0, r, 0);
      step(1'b0, 4'h0);
      check_outs("bad_after", (r == MAX_FAIL - 1) ? ST_LOCKOUT : ST_IDLE, 0, r + 1, 0);
    end
  endtask

  function automatic logic [15:0] model_pin_word();
    logic [15:0] w;
    w = '0;
    foreach (m_pin[i]) w = {w[11:0], 4'(m_pin[i])};
    return w << (4 * (4 - PIN_LEN));
  endfunction

  typedef struct {
    logic       v;
    logic [3:0] c;
    int         st, cnt, fl, bp;
  } vec_t;
  vec_t vecs[26];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'h1,    ST_ENTRY,  1, 0, 1};
    vecs[1]  = '{1'b1, 4'h2,    ST_ENTRY,  2, 0, 1};
    vecs[2]  = '{1'b1, 4'h3,    ST_ENTRY,  3, 0, 1};
    vecs[3]  = '{1'b1, 4'h4,    ST_ENTRY,  4, 0, 1};
    vecs[4]  = '{1'b1, 4'h9,    ST_ENTRY,  4, 0, 0};
    vecs[5]  = '{1'b1, K_ENTER, ST_CHECK,  4, 0, 1};
    vecs[6]  = '{1'b0, 4'h0,    ST_UNLOCK, 0, 0, 0};
    vecs[7]  = '{1'b0, 4'h0,    ST_UNLOCK, 0, 0, 0};
    vecs[8]  = '{1'b1, K_LOCK,  ST_IDLE,   0, 0, 1};
    vecs[9]  = '{1'b1, 4'h1,    ST_ENTRY,  1, 0, 1};
    vecs[10] = '{1'b1, 4'h2,    ST_ENTRY,  2, 0, 1};
    vecs[11] = '{1'b1, K_ENTER, ST_CHECK,  2, 0, 1};
    vecs[12] = '{1'b0, 4'h0,    ST_FAIL,   0, 0, 0};
    vecs[13] = '{1'b0, 4'h0,    ST_IDLE,   0, 1, 0};
    vecs[14] = '{1'b1, 4'h1,    ST_ENTRY,  1, 1, 1};
    vecs[15] = '{1'b1, 4'h2,    ST_ENTRY,  2, 1, 1};
    vecs[16] = '{1'b1, K_CLEAR, ST_IDLE,   0, 1, 1};
    vecs[17] = '{1'b1, K_ENTER, ST_IDLE,   0, 1, 1};
    vecs[18] = '{1'b1, K_LOCK,  ST_IDLE,   0, 1, 1};
    vecs[19] = '{1'b1, 4'hE,    ST_IDLE,   0, 1, 0};
    vecs[20] = '{1'b1, K_SETPIN,ST_IDLE,   0, 1, 0};
    vecs[21] = '{1'b1, 4'h5,    ST_ENTRY,  1, 1, 1};
    vecs[22] = '{1'b1, K_LOCK,  ST_ENTRY,  1, 1, 0};
    vecs[23] = '{1'b1, K_SETPIN,ST_ENTRY,  1, 1, 0};
    vecs[24] = '{1'b0, K_ENTER, ST_ENTRY,  1, 1, 0};
    vecs[25] = '{1'b1, K_CLEAR, ST_IDLE,   0, 1, 1};

    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", ST_IDLE, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].c);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].fl, vecs[i].bp);
    end

    // auto-relock after UNLOCK_CYCLES idle cycles
    reset_check("rst_after_table");
    enter_code(16'h1234, 4);
    check_outs("unl_enter", ST_CHECK, 4, 0, 1);
    step(1'b0, 4'h0);
    check_outs("unl_entry", ST_UNLOCK, 0, 0, 0);
    for (int i = 1; i < UNLOCK_CYCLES; i++) begin
      step(1'b0, 4'h0);
      check_outs("unl_hold", ST_UNLOCK, 0, 0, 0);
    end
    step(1'b0, 4'h0);
    check_outs("unl_timeout", ST_IDLE, 0, 0, 0);

    // LOCK on the expiry cycle is dropped in favour of the timer
    enter_code(16'h1234, 4);
    step(1'b0, 4'h0);
    repeat (UNLOCK_CYCLES - 1) step(1'b0, 4'h0);
    step(1'b1, K_LOCK);
    check_outs("unl_lock_at_expiry", ST_IDLE, 0, 0, 0);

    // three bad PINs, lockout ignores keys, digit at expiry dropped
    fail_to_lockout();
    step(1'b1, 4'h1);
    check_outs("lock_key", ST_LOCKOUT, 0, 3, 0);
    for (int i = 0; i < LOCKOUT_CYCLES - 2; i++) begin
      step(1'b0, 4'h0);
      check_outs("lock_hold", ST_LOCKOUT, 0, 3, 0);
    end
    step(1'b1, 4'h7);
    check_outs("lock_expiry", ST_IDLE, 0, 0, 0);

    // asynchronous reset from UNLOCK and from mid-lockout
    enter_code(16'h1234, 4);
    repeat (2) step(1'b0, 4'h0);
    reset_check("rst_unlock");
    fail_to_lockout();
    repeat (5) step(1'b0, 4'h0);
    reset_check("rst_lockout");

`ifdef SAFE_PIN_CHANGE_EN
    enter_code(16'h1234, 4);
    step(1'b0, 4'h0);
    step(1'b1, K_SETPIN);
    check_outs("sp_enter", ST_SETPIN, 0, 0, 1);
    enter_code(16'h9876, 4);
    check_outs("sp_store", ST_IDLE, 0, 0, 1);
    enter_code(16'h1234, 4);
    step(1'b0, 4'h0);
    check_outs("sp_old_fails", ST_FAIL, 0, 0, 0);
    step(1'b0, 4'h0);
    check_outs("sp_old_idle", ST_IDLE, 0, 1, 0);
    enter_code(16'h9876, 4);
    step(1'b0, 4'h0);
    check_outs("sp_new_unlocks", ST_UNLOCK, 0, 0, 0);
    step(1'b1, K_SETPIN);
    enter_code(16'h5500, 2);
    check_outs("sp_short_abort", ST_IDLE, 0, 0, 1);
    enter_code(16'h9876, 4);
    step(1'b0, 4'h0);
    check_outs("sp_pin_kept", ST_UNLOCK, 0, 0, 0);
    step(1'b1, K_LOCK);
    check_outs("sp_relock", ST_IDLE, 0, 0, 1);
`else
    enter_code(16'h1234, 4);
    step(1'b0, 4'h0);
    step(1'b1, K_SETPIN);
    check_outs("sp_ignored", ST_UNLOCK, 0, 0, 0);
    step(1'b1, K_LOCK);
    check_outs("sp_relock", ST_IDLE, 0, 0, 1);
`endif

    // randomized key streams against the model
    reset_check("rst_random");
    for (int b = 0; b < 400; b++) begin
      case ($urandom_range(0, 5))
        0: enter_code(model_pin_word(), PIN_LEN);
        1: begin
          int n;
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) step(1'b1, 4'($urandom_range(0, 9)));
          step(1'b1, K_ENTER);
        end
        2, 3: step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        4: repeat ($urandom_range(1, 12)) step(1'b0, 4'($urandom_range(0, 15)));
        default: step(1'b1, ($urandom_range(0, 1) == 0) ? K_LOCK : K_SETPIN);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
